// File: rtl/sdiv_pkg.sv
// sdiv_pkg: shared types and constants for the sequential signed divider.
//   state_t    - divider FSM states (IDLE, LOAD, CALC, FIX)
//   N_W_DEF    - default dividend/quotient width
//   D_W_DEF    - default divisor/remainder width
//   cnt_w()    - iteration counter width for a given dividend width
package sdiv_pkg;

    localparam int N_W_DEF   = 32;
    localparam int D_W_DEF   = 16;

    // Counter must be able to hold the value N_W.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(N_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/sdiv_step.sv
// sdiv_step: one combinational restoring-division step on magnitudes.
//   rem     [D_W-1:0] in  : current partial remainder (always < babs)
//   dbit              in  : next dividend bit, MSB first
//   babs    [D_W-1:0] in  : divisor magnitude
//   rem_nxt [D_W-1:0] out : partial remainder after this step
//   qbit              out : quotient bit produced by this step
module sdiv_step #(
    parameter int D_W = 16
) (
    input  logic [D_W-1:0] rem,
    input  logic           dbit,
    input  logic [D_W-1:0] babs,
    output logic [D_W-1:0] rem_nxt,
    output logic           qbit
);

    logic [D_W:0] part;
    logic [D_W:0] diff;

    always_comb begin
        part = {rem, dbit};
        diff = part - {1'b0, babs};
        qbit = (part >= {1'b0, babs});
        // Both branches fit in D_W bits: after subtracting the result is
        // below babs, and when not subtracting part itself is below babs.
        rem_nxt = qbit ? diff[D_W-1:0] : part[D_W-1:0];
    end

endmodule

// File: rtl/sdiv_seq.sv
// sdiv_seq: sequential signed divider, one quotient bit per clock
// (restoring shift/subtract), truncating toward zero like Verilog / and %.
//   CLK, RST          : clock, synchronous active-low reset
//   START, A, B       : launch pulse with signed dividend / divisor,
//                       sampled only while idle
//   BUSY              : high from LOAD through the last CALC cycle
//   VALID             : one-cycle result strobe, N_W+2 cycles after accept
//   Q, R, DIV0, OVF   : registered results, held until the next VALID
// Build option: define SDIV_REM_EN to build the signed remainder output;
// without it R is tied to 0 and everything else is unchanged.
module sdiv_seq
    import sdiv_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [N_W-1:0] A,
    input  logic [D_W-1:0] B,
    output logic           BUSY,
    output logic           VALID,
    output logic [N_W-1:0] Q,
    output logic [D_W-1:0] R,
    output logic           DIV0,
    output logic           OVF
);

    localparam int             CW    = cnt_w(N_W);
    localparam logic [N_W-1:0] A_MIN = {1'b1, {(N_W-1){1'b0}}};

    state_t         st;
    logic [N_W-1:0] a_l;      // operands latched at accept
    logic [D_W-1:0] b_l;
    logic [N_W-1:0] dq;       // dividend bits shift out, quotient bits shift in
    logic [D_W-1:0] rem;
    logic [D_W-1:0] babs;
    logic           qneg;
    logic           div0_l;
    logic           ovf_l;
    logic [CW-1:0]  cnt;

    logic [N_W-1:0] a_mag;
    logic [D_W-1:0] b_mag;
    logic [D_W-1:0] rem_nxt;
    logic           qbit;
    logic [N_W-1:0] uq;
    logic [N_W-1:0] q_fix;

    // -A_MIN wraps to A_MIN, which read as unsigned is the right magnitude.
    assign a_mag = a_l[N_W-1] ? -a_l : a_l;
    assign b_mag = b_l[D_W-1] ? -b_l : b_l;

    sdiv_step #(.D_W(D_W)) u_step (
        .rem     (rem),
        .dbit    (dq[N_W-1]),
        .babs    (babs),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // Final values are formed from the last step directly, so results land
    // on the same edge that raises VALID.
    assign uq    = {dq[N_W-2:0], qbit};
    assign q_fix = div0_l ? '1 : (qneg ? -uq : uq);

`ifdef SDIV_REM_EN
    logic           rneg;     // remainder follows the dividend's sign
    logic [D_W-1:0] r_fix;
    assign r_fix = div0_l ? '0 : (rneg ? -rem_nxt : rem_nxt);
`else
    assign R = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            st     <= IDLE;
            a_l    <= '0;
            b_l    <= '0;
            dq     <= '0;
            rem    <= '0;
            babs   <= '0;
            qneg   <= 1'b0;
            div0_l <= 1'b0;
            ovf_l  <= 1'b0;
            cnt    <= '0;
            BUSY   <= 1'b0;
            VALID  <= 1'b0;
            Q      <= '0;
            DIV0   <= 1'b0;
            OVF    <= 1'b0;
`ifdef SDIV_REM_EN
            rneg   <= 1'b0;
            R      <= '0;
`endif
        end else begin
            VALID <= 1'b0;
            case (st)
                IDLE: begin
                    if (START) begin
                        a_l  <= A;
                        b_l  <= B;
                        BUSY <= 1'b1;
                        st   <= LOAD;
                    end
                end
                LOAD: begin
                    dq     <= a_mag;
                    babs   <= b_mag;
                    rem    <= '0;
                    qneg   <= a_l[N_W-1] ^ b_l[D_W-1];
                    div0_l <= (b_l == '0);
                    ovf_l  <= (a_l == A_MIN) && (b_l == '1);
                    cnt    <= '0;
`ifdef SDIV_REM_EN
                    rneg   <= a_l[N_W-1];
`endif
                    st     <= CALC;
                end
                CALC: begin
                    dq  <= uq;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N_W-1)) begin
                        Q     <= q_fix;
                        DIV0  <= div0_l;
                        OVF   <= ovf_l;
`ifdef SDIV_REM_EN
                        R     <= r_fix;
`endif
                        VALID <= 1'b1;
                        BUSY  <= 1'b0;
                        st    <= FIX;
                    end
                end
                FIX:     st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq: directed vectors with literal expectations plus a
// per-cycle reference built from plain signed division and the handshake
// timing (accept edge, result N_W+1 edges later, idle one edge after that).
module tb_sdiv_seq;

    localparam int N_W = 32;
    localparam int D_W = 16;
`ifdef SDIV_REM_EN
    localparam bit REM_ON = 1'b1;
`else
    localparam bit REM_ON = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           START = 1'b0;
    logic [N_W-1:0] A = '0;
    logic [D_W-1:0] B = '0;
    logic           BUSY, VALID, DIV0, OVF;
    logic [N_W-1:0] Q;
    logic [D_W-1:0] R;

    sdiv_seq #(.N_W(N_W), .D_W(D_W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .BUSY(BUSY), .VALID(VALID), .Q(Q), .R(R), .DIV0(DIV0), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference result from ordinary signed arithmetic.
    function automatic void ref_div(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                                    output logic [N_W-1:0] q, output logic [D_W-1:0] r,
                                    output bit d0, output bit ov);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        d0 = 1'b0; ov = 1'b0;
        if (sb == 0) begin
            q = '1; r = '0; d0 = 1'b1;
        end else if (sa == -(64'sd1 <<< (N_W-1)) && sb == -1) begin
            q = a; r = '0; ov = 1'b1;
        end else begin
            q = N_W'(sa / sb);
            r = D_W'(sa % sb);
        end
        if (!REM_ON) r = '0;
    endfunction

    // Reference handshake/result model, advanced on every clock edge.
    bit             m_idle = 1'b1;
    int             m_t = 0;
    logic           e_valid = 0, e_busy = 0, e_d0 = 0, e_ov = 0;
    logic [N_W-1:0] e_q = '0, p_q;
    logic [D_W-1:0] e_r = '0, p_r;
    bit             p_d0, p_ov;

    always @(posedge CLK) begin
        if (!RST) begin
            m_idle = 1'b1; e_valid = 0; e_busy = 0;
            e_q = '0; e_r = '0; e_d0 = 0; e_ov = 0;
        end else if (m_idle) begin
            if (START) begin
                m_idle = 1'b0; m_t = 0; e_busy = 1'b1;
                ref_div(A, B, p_q, p_r, p_d0, p_ov);
            end
        end else begin
            m_t++;
            if (m_t == N_W + 1) begin
                e_valid = 1'b1; e_busy = 1'b0;
                e_q = p_q; e_r = p_r; e_d0 = p_d0; e_ov = p_ov;
            end else if (m_t == N_W + 2) begin
                e_valid = 1'b0; m_idle = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("valid", 64'(VALID), 64'(e_valid));
            chk("busy",  64'(BUSY),  64'(e_busy));
            chk("q",     64'(Q),     64'(e_q));
            chk("r",     64'(R),     64'(e_r));
            chk("div0",  64'(DIV0),  64'(e_d0));
            chk("ovf",   64'(OVF),   64'(e_ov));
        end
    end

    // k = negedges after the accept edge until VALID is seen; spec cycle = k+1.
    task automatic wait_valid(output int k);
        k = 0;
        while (VALID !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
    endtask

    task automatic op(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                      input logic [N_W-1:0] xq, input logic [D_W-1:0] xr,
                      input bit xd, input bit xo);
        int k;
        @(negedge CLK);
        A = a; B = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A = ~a; B = ~b;               // operands may change after accept
        wait_valid(k);
        chk("latency", 64'(k + 1), 64'(N_W + 2));
        chk("lit_q",    64'(Q),    64'(xq));
        chk("lit_r",    64'(R),    64'(REM_ON ? xr : '0));
        chk("lit_div0", 64'(DIV0), 64'(xd));
        chk("lit_ovf",  64'(OVF),  64'(xo));
    endtask

    typedef struct {
        logic [31:0] a; logic [15:0] b; logic [31:0] q; logic [15:0] r; bit d; bit o;
    } vec_t;
    vec_t tbl [15];

    initial begin
        int k, last, gap;
        tbl = '{
            '{32'd100000,     16'd7,      32'd14285,     16'd5,      1'b0, 1'b0},
            '{32'hFFFE7960,   16'd7,      32'hFFFFC833,  16'hFFFB,   1'b0, 1'b0},
            '{32'd100000,     16'hFFF9,   32'hFFFFC833,  16'd5,      1'b0, 1'b0},
            '{32'd1234,       16'd0,      32'hFFFFFFFF,  16'd0,      1'b1, 1'b0},
            '{32'h80000000,   16'hFFFF,   32'h80000000,  16'd0,      1'b0, 1'b1},
            '{32'd7,          16'd2,      32'd3,         16'd1,      1'b0, 1'b0},
            '{32'hFFFFFFF9,   16'd2,      32'hFFFFFFFD,  16'hFFFF,   1'b0, 1'b0},
            '{32'd7,          16'hFFFE,   32'hFFFFFFFD,  16'd1,      1'b0, 1'b0},
            '{32'hFFFFFFF9,   16'hFFFE,   32'd3,         16'hFFFF,   1'b0, 1'b0},
            '{32'd0,          16'd5,      32'd0,         16'd0,      1'b0, 1'b0},
            '{32'h7FFFFFFF,   16'd1,      32'h7FFFFFFF,  16'd0,      1'b0, 1'b0},
            '{32'h80000000,   16'd1,      32'h80000000,  16'd0,      1'b0, 1'b0},
            '{32'h80000000,   16'h8000,   32'd65536,     16'd0,      1'b0, 1'b0},
            '{32'hFFFFFFFF,   16'h8000,   32'd0,         16'hFFFF,   1'b0, 1'b0},
            '{32'h7FFFFFFF,   16'h7FFF,   32'd65538,     16'd1,      1'b0, 1'b0}
        };

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_valid", 64'(VALID), 64'd0);
        chk("rst_busy",  64'(BUSY),  64'd0);
        chk("rst_q",     64'(Q),     64'd0);
        chk("rst_r",     64'(R),     64'd0);
        chk_en = 1'b1;
        RST = 1'b1;

        foreach (tbl[i]) op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].d, tbl[i].o);

        // Reset mid-operation: accept at edge 0, reset at edge 10, relaunch at 12.
        @(negedge CLK);
        A = 32'd100000; B = 16'd7; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        chk("abort_q",    64'(Q),     64'd0);
        chk("abort_busy", 64'(BUSY),  64'd0);
        chk("abort_div0", 64'(DIV0),  64'd0);
        @(negedge CLK);
        A = 32'd1000; B = 16'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_valid(k);
        chk("restart_cycle", 64'(12 + k + 1), 64'd46);
        chk("restart_q",     64'(Q),          64'd333);

        // START held high with operands churning every cycle.
        @(negedge CLK);
        START = 1'b1;
        last = -1;
        for (int c = 0; c < 4 * (N_W + 3); c++) begin
            A = $urandom;
            B = ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom);
            @(negedge CLK);
            if (VALID === 1'b1) begin
                if (last >= 0) begin
                    gap = c - last;
                    chk("issue_gap", 64'(gap), 64'(N_W + 3));
                end
                last = c;
            end
        end
        START = 1'b0;
        repeat (N_W + 5) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
